// File: rtl/pin_out_sequencer.sv
// rtl/pin_out_sequencer.sv - MSB-first word serializer driving output IO register D/enable pins
// Define PIN_SEQ_PARITY_EN to append one even-parity bit after bit 0.
module pin_out_sequencer #(
  parameter int   DATA_W   = 8,
  parameter int   DIV      = 4,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              IOL_D,
  output logic              IOL_SP,
  output logic              IOL_FRAME,
  output logic              TX_DONE,
  output logic              BUSY
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] word, word_n;
  logic              cnt_wrap;
  logic              bit_n, d_n, sp_n, frame_n, done_n;
`ifdef PIN_SEQ_PARITY_EN
  logic              par_phase, par_phase_n;
  logic              par_bit, par_bit_n;
`endif

  assign TX_READY = (state == IDLE);
  assign cnt_wrap = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    word_n  = word;
`ifdef PIN_SEQ_PARITY_EN
    par_phase_n = par_phase;
    par_bit_n   = par_bit;
`endif
    case (state)
      IDLE: begin
        if (TX_VALID) begin
          word_n  = TX_DATA;
          idx_n   = IDX_TOP;
          cnt_n   = '0;
          state_n = SHIFT;
`ifdef PIN_SEQ_PARITY_EN
          par_phase_n = 1'b0;
          par_bit_n   = ^TX_DATA;
`endif
        end
      end
      SHIFT: begin
        if (!cnt_wrap) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = '0;
`ifdef PIN_SEQ_PARITY_EN
          if (par_phase)       state_n     = GAP;
          else if (idx == '0)  par_phase_n = 1'b1;
          else                 idx_n       = idx - 1'b1;
`else
          if (idx == '0) state_n = GAP;
          else           idx_n   = idx - 1'b1;
`endif
        end
      end
      GAP: begin
        if (!cnt_wrap) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up with it.
`ifdef PIN_SEQ_PARITY_EN
    bit_n = par_phase_n ? par_bit_n : word_n[idx_n];
`else
    bit_n = word_n[idx_n];
`endif
    d_n     = IDLE_LVL;
    sp_n    = 1'b0;
    frame_n = 1'b0;
    done_n  = 1'b0;
    case (state_n)
      SHIFT: begin
        d_n     = bit_n;
        sp_n    = (cnt_n == '0);
        frame_n = 1'b1;
      end
      GAP: begin
        sp_n   = (cnt_n == '0);
        done_n = (cnt_n == CNT_LAST);
      end
      default: ;
    endcase
  end

  // IOL_SP stays high in reset so the IO registers keep loading the idle levels.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      word      <= '0;
      IOL_D     <= IDLE_LVL;
      IOL_SP    <= 1'b1;
      IOL_FRAME <= 1'b0;
      TX_DONE   <= 1'b0;
      BUSY      <= 1'b0;
`ifdef PIN_SEQ_PARITY_EN
      par_phase <= 1'b0;
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      word      <= word_n;
      IOL_D     <= d_n;
      IOL_SP    <= sp_n;
      IOL_FRAME <= frame_n;
      TX_DONE   <= done_n;
      BUSY      <= (state_n != IDLE);
`ifdef PIN_SEQ_PARITY_EN
      par_phase <= par_phase_n;
      par_bit   <= par_bit_n;
`endif
    end
  end

endmodule

// File: tb/tb_pin_out_sequencer.sv
// tb/tb_pin_out_sequencer.sv - scoreboard bench for pin_out_sequencer (DIV=4 and DIV=1 instances)
module tb_pin_out_sequencer;

  localparam int   DATA_W   = 8;
  localparam int   DIV      = 4;
  localparam logic IDLE_LVL = 1'b1;
`ifdef PIN_SEQ_PARITY_EN
  localparam int   NB       = DATA_W + 1;
`else
  localparam int   NB       = DATA_W;
`endif
  localparam int   PERIOD   = (NB + 1) * DIV + 1;

  typedef struct {
    int   cyc;
    logic d;
    logic frame;
  } pulse_t;

  logic              ck = 1'b0;
  logic              rstn = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready, iol_d, iol_sp, iol_frame, tx_done, busy;
  logic [DATA_W-1:0] tx_data1 = '0;
  logic              tx_valid1 = 1'b0;
  logic              tx_ready1, iol_d1, iol_sp1, iol_frame1, tx_done1, busy1;

  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  pulse_t sb[$];
  pulse_t sb1[$];
  int     done_q[$];
  int     hs_cyc[$];
  int     hs1 = 0;
  int     ready_gap1 = 0;

  pin_out_sequencer #(.DATA_W(DATA_W), .DIV(DIV), .IDLE_LVL(IDLE_LVL)) u_dut (
    .CK(ck), .RSTN(rstn), .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .IOL_D(iol_d), .IOL_SP(iol_sp), .IOL_FRAME(iol_frame), .TX_DONE(tx_done), .BUSY(busy)
  );

  pin_out_sequencer #(.DATA_W(DATA_W), .DIV(1), .IDLE_LVL(IDLE_LVL)) u_dut1 (
    .CK(ck), .RSTN(rstn), .TX_DATA(tx_data1), .TX_VALID(tx_valid1), .TX_READY(tx_ready1),
    .IOL_D(iol_d1), .IOL_SP(iol_sp1), .IOL_FRAME(iol_frame1), .TX_DONE(tx_done1), .BUSY(busy1)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Main instance: every enable pulse and done pulse is matched against the queue.
  always @(negedge ck) begin
    if (rstn && iol_sp && busy) begin
      if (sb.size() == 0) check("sp_unexpected", 1, 0);
      else begin
        pulse_t e;
        e = sb.pop_front();
        check("sp_cycle", cyc, e.cyc);
        check("sp_d", iol_d, e.d);
        check("sp_frame", iol_frame, e.frame);
      end
    end
    if (rstn && tx_done) begin
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else check("done_cycle", cyc, done_q.pop_front());
    end
    if (rstn && tx_valid && tx_ready) begin
      hs_cyc.push_back(cyc);
      for (int i = 0; i < DATA_W; i++)
        sb.push_back('{cyc + 1 + i * DIV, tx_data[DATA_W-1-i], 1'b1});
`ifdef PIN_SEQ_PARITY_EN
      sb.push_back('{cyc + 1 + DATA_W * DIV, ^tx_data, 1'b1});
`endif
      sb.push_back('{cyc + 1 + NB * DIV, IDLE_LVL, 1'b0});
      done_q.push_back(cyc + (NB + 1) * DIV);
    end
  end

  // DIV=1 instance: the enable must be high in every busy cycle.
  always @(negedge ck) begin
    if (rstn && busy1) begin
      check("div1_sp", iol_sp1, 1);
      if (sb1.size() == 0) check("div1_unexpected", 1, 0);
      else begin
        pulse_t e;
        e = sb1.pop_front();
        check("div1_cycle", cyc, e.cyc);
        check("div1_d", iol_d1, e.d);
        check("div1_frame", iol_frame1, e.frame);
      end
    end
    if (rstn && tx_ready1 && hs1 == 1) ready_gap1++;
    if (rstn && tx_valid1 && tx_ready1) begin
      hs1++;
      for (int i = 0; i < DATA_W; i++)
        sb1.push_back('{cyc + 1 + i, tx_data1[DATA_W-1-i], 1'b1});
`ifdef PIN_SEQ_PARITY_EN
      sb1.push_back('{cyc + 1 + DATA_W, ^tx_data1, 1'b1});
`endif
      sb1.push_back('{cyc + 1 + NB, IDLE_LVL, 1'b0});
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge ck);
      n++;
    end while (!tx_ready && n < 200);
    if (!tx_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !tx_ready || !tx_ready1) && n < 200) begin
      @(negedge ck);
      n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    @(posedge ck); #1;
    tx_data  = w;
    tx_valid = 1'b1;
    wait_ready();
    @(posedge ck); #1;
    tx_valid = 1'b0;
  endtask

  task automatic send_scrambled(input logic [DATA_W-1:0] w);
    int n = 0;
    tx_valid = 1'b1;
    do begin
      @(posedge ck); #1;
      tx_data = tx_ready ? w : DATA_W'($urandom);
      n++;
    end while (!tx_ready && n < 200);
    if (!tx_ready) check("scramble_timeout", 0, 1);
    @(posedge ck); #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge ck);
    check("rst_d", iol_d, IDLE_LVL);
    check("rst_sp", iol_sp, 1);
    check("rst_frame", iol_frame, 0);
    check("rst_done", tx_done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_sp_div1", iol_sp1, 1);
    @(posedge ck); #1 rstn = 1'b1;
    repeat (2) @(negedge ck);
    check("sp_after_release", iol_sp, 0);
    check("d_idle", iol_d, IDLE_LVL);

    // DIV=1: 0x00 then 0xFF with valid held high.
    @(posedge ck); #1;
    tx_data1  = 8'h00;
    tx_valid1 = 1'b1;
    @(negedge ck);
    @(posedge ck); #1 tx_data1 = 8'hFF;
    begin
      int n = 0;
      do begin
        @(negedge ck);
        n++;
      end while (!tx_ready1 && n < 100);
      if (!tx_ready1) check("div1_timeout", 0, 1);
    end
    @(posedge ck); #1 tx_valid1 = 1'b0;
    wait_idle();
    check("div1_handshakes", hs1, 2);
    check("div1_ready_gap", ready_gap1, 1);

    // Reference word with known pulse timing.
    send_word(8'hA5);
    wait_idle();

    // Back-to-back words with valid held: period and parity bits.
    hs_cyc.delete();
    @(posedge ck); #1;
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    wait_ready();
    @(posedge ck); #1 tx_data = 8'h03;
    wait_ready();
    @(posedge ck); #1 tx_valid = 1'b0;
    wait_idle();
    check("hs_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) check("word_period", hs_cyc[1] - hs_cyc[0], PERIOD);

    // Valid held while busy with TX_DATA churning.
    send_word(8'h5A);
    send_scrambled(8'hC3);
    wait_idle();

    // Reset in the middle of 0x3C.
    send_word(8'h3C);
    repeat (16) @(posedge ck);
    #1 rstn = 1'b0;
    sb.delete();
    done_q.delete();
    #1;
    check("midrst_d", iol_d, IDLE_LVL);
    check("midrst_sp", iol_sp, 1);
    check("midrst_frame", iol_frame, 0);
    check("midrst_done", tx_done, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(posedge ck);
    #1 rstn = 1'b1;
    repeat (2) @(negedge ck);
    check("midrst_sp_release", iol_sp, 0);
    send_word(8'h81);
    wait_idle();

    for (int k = 0; k < 4; k++) begin
      send_word(DATA_W'($urandom));
      wait_idle();
    end

    repeat (3) @(negedge ck);
    check("sb_empty", sb.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("sb1_empty", sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
